// File: rtl/full_subtractor.sv
// Registered WIDTH-bit subtractor built as a ripple chain of 1-bit full subtractors.
// One-cycle latency; out_valid tracks in_valid. Async active-low reset clears all outputs.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic             w_borrow;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_valid;

    // Returns {difference, borrow-out} of a single bit stage.
    function automatic logic [1:0] fs_bit(
        input logic a,
        input logic b,
        input logic bi
    );
        logic d;
        logic bo;
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~a & bi) | (b & bi);
        return {d, bo};
    endfunction

    always_comb begin
        logic [1:0] w_stage;
        w_diff   = '0;
        w_borrow = Bin;
        w_stage  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_stage   = fs_bit(A[i], B[i], w_borrow);
            w_diff[i] = w_stage[1];
            w_borrow  = w_stage[0];
        end
        w_bout = w_borrow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_d     <= w_diff;
            r_bout  <= w_bout;
            r_valid <= in_valid;
        end
    end

    assign D         = r_d;
    assign Bout      = r_bout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor at WIDTH 1, 8 and 64 against an arithmetic model.
// Directed literal vectors, async reset checks, then randomized traffic.
module tb_full_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a1, b1, c1, v1, d1, bo1, ov1;
    logic [7:0]  a8, b8, d8;
    logic        c8, v8, bo8, ov8;
    logic [63:0] a64, b64, d64;
    logic        c64, v64, bo64, ov64;

    int nvec = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Bin(c1), .in_valid(v1),
        .D(d1), .Bout(bo1), .out_valid(ov1)
    );
    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Bin(c8), .in_valid(v8),
        .D(d8), .Bout(bo8), .out_valid(ov8)
    );
    full_subtractor #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .A(a64), .B(b64), .Bin(c64), .in_valid(v64),
        .D(d64), .Bout(bo64), .out_valid(ov64)
    );

    // Model result packed as {borrow, 64-bit difference}.
    function automatic logic [64:0] sub_model(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        c,
        input int          w
    );
        logic [63:0] mask;
        logic [64:0] r;
        logic [63:0] a_m;
        logic [63:0] b_m;
        logic        bo;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a_m  = a & mask;
        b_m  = b & mask;
        r    = {1'b0, a_m} - {1'b0, b_m} - {64'd0, c};
        bo   = ({1'b0, a_m} < ({1'b0, b_m} + {64'd0, c}));
        return {bo, r[63:0] & mask};
    endfunction

    task automatic cmp(input string name, input logic [64:0] act, input logic [64:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [64:0] e1, e8, e64;
    logic        ev1, ev8, ev64;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1 <= '0; e8 <= '0; e64 <= '0;
            ev1 <= 1'b0; ev8 <= 1'b0; ev64 <= 1'b0;
        end else begin
            e1   <= sub_model({63'd0, a1}, {63'd0, b1}, c1, 1);
            e8   <= sub_model({56'd0, a8}, {56'd0, b8}, c8, 8);
            e64  <= sub_model(a64, b64, c64, 64);
            ev1  <= v1;
            ev8  <= v8;
            ev64 <= v64;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("w1_res", {bo1, 63'd0, d1}, e1);
            cmp("w8_res", {bo8, 56'd0, d8}, e8);
            cmp("w64_res", {bo64, d64}, e64);
            cmp("w1_valid", {64'd0, ov1}, {64'd0, ev1});
            cmp("w8_valid", {64'd0, ov8}, {64'd0, ev8});
            cmp("w64_valid", {64'd0, ov64}, {64'd0, ev64});
        end
    end

    task automatic rnd_pair(output logic [63:0] a, output logic [63:0] b);
        int k;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        k = $urandom_range(0, 7);
        if (k == 0) b = a;
        else if (k == 1) begin a = '0; b = '1; end
        else if (k == 2) a = '0;
        else if (k == 3) b = '1;
    endtask

    logic [15:0] w1_tbl;
    logic [1:0]  w1_exp;
    logic [2:0]  w1_in;

    initial begin
        logic [63:0] ra, rb;
        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        a8 = 0; b8 = 0; c8 = 0; v8 = 0;
        a64 = 0; b64 = 0; c64 = 0; v64 = 0;
        w1_tbl = 16'b00_11_11_01_10_00_00_11;

        repeat (2) @(negedge clk);
        cmp("reset_w1", {ov1, bo1, 63'd0, d1}, '0);
        cmp("reset_w8", {ov8, bo8, 56'd0, d8}, '0);
        cmp("reset_w64", {ov64, bo64, d64}, {1'b0, 64'd0});
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Truth table for the 1-bit stage, back to back.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                w1_in  = 3'(i - 1);
                w1_exp = w1_tbl[15 - 2*(i-1) -: 2];
                cmp("tt_dut", {63'd0, d1, bo1}, {63'd0, w1_exp});
                cmp("tt_model", sub_model({63'd0, w1_in[2]}, {63'd0, w1_in[1]}, w1_in[0], 1),
                    {w1_exp[0], 63'd0, w1_exp[1]});
            end
            if (i < 8) begin
                w1_in = 3'(i);
                a1 = w1_in[2]; b1 = w1_in[1]; c1 = w1_in[0]; v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
        end

        @(negedge clk); a8 = 8'h05; b8 = 8'h03; c8 = 1'b1; v8 = 1'b1;
        @(negedge clk);
        cmp("w8_5m3m1", {bo8, 56'd0, d8}, {1'b0, 64'h01});
        cmp("model_5m3m1", sub_model(64'h05, 64'h03, 1'b1, 8), {1'b0, 64'h01});
        a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1;
        @(negedge clk);
        cmp("w8_0mFFm1", {bo8, 56'd0, d8}, {1'b1, 64'h00});
        cmp("model_0mFFm1", sub_model(64'h00, 64'hFF, 1'b1, 8), {1'b1, 64'h00});
        a8 = 8'h10; b8 = 8'h10; c8 = 1'b1;
        @(negedge clk);
        cmp("w8_eq_m1", {bo8, 56'd0, d8}, {1'b1, 64'hFF});
        cmp("model_eq_m1", sub_model(64'h10, 64'h10, 1'b1, 8), {1'b1, 64'hFF});
        a8 = 8'h10; b8 = 8'h10; c8 = 1'b0;
        @(negedge clk);
        cmp("w8_eq", {bo8, 56'd0, d8}, {1'b1, 64'h00} & {1'b0, 64'h00});
        v8 = 1'b0;
        a64 = 64'd0; b64 = '1; c64 = 1'b1; v64 = 1'b1;
        @(negedge clk);
        cmp("w64_0mmax", {bo64, d64}, {1'b1, 64'd0});
        v64 = 1'b0;

        // Single-cycle valid pulse.
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        cmp("pulse_hi", {62'd0, ov1, d1, bo1}, {62'd0, 3'b110});
        v1 = 1'b0;
        @(negedge clk);
        cmp("pulse_lo", {64'd0, ov1}, 65'd0);

        // Asynchronous reset between edges.
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        cmp("pre_rst", {62'd0, ov1, d1, bo1}, {62'd0, 3'b111});
        #2 rst_n = 1'b0;
        #1 cmp("rst_async", {62'd0, ov1, d1, bo1}, 65'd0);
        @(posedge clk); #1;
        cmp("rst_hold", {62'd0, ov1, d1, bo1}, 65'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 cmp("rst_released", {62'd0, ov1, d1, bo1}, 65'd0);
        @(posedge clk); #1;
        cmp("first_edge", {62'd0, ov1, d1, bo1}, {62'd0, 3'b111});

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rnd_pair(ra, rb);
            a1 = ra[0]; b1 = rb[0]; c1 = 1'($urandom()); v1 = 1'($urandom());
            rnd_pair(ra, rb);
            a8 = ra[7:0]; b8 = rb[7:0]; c8 = 1'($urandom()); v8 = 1'($urandom());
            rnd_pair(ra, rb);
            a64 = ra; b64 = rb; c64 = 1'($urandom()); v64 = 1'($urandom());
        end
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 Parameter: WIDTH, 1, operand/difference width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: A  input  WIDTH  minuend.
REQ-005 Port: B  input  WIDTH  subtrahend.
REQ-006 Port: Bin  input  1  borrow-in.
REQ-007 Port: in_valid  input  1  marks A/B/Bin as a valid operation this cycle.
REQ-008 Port: D  output  WIDTH  registered difference.
REQ-009 Port: Bout  output  1  registered borrow-out.
REQ-010 Port: out_valid  output  1  marks D/Bout as the result of a valid operation.

Function
REQ-011 Arithmetic SHALL compute the WIDTH+1-bit quantity R = {1'b0,A} - {1'b0,B} - Bin, unsigned.
REQ-012 D SHALL be R[WIDTH-1:0], i.e. (A - B - Bin) mod 2^WIDTH.
REQ-013 Bout SHALL be 1 exactly when A < B + Bin (unsigned compare with B + Bin widened to WIDTH+1 bits), else 0.
REQ-014 For WIDTH=1 this SHALL reduce to D = A^B^Bin, Bout = (~A&B)|(~A&Bin)|(B&Bin).
REQ-015 For WIDTH>1 the result SHALL equal a ripple chain of 1-bit full subtractors, LSB first, Bin into bit 0, Bout from the MSB stage.
REQ-016 Latency SHALL be exactly one clock: inputs sampled at edge N appear on D/Bout at edge N.
REQ-017 D and Bout SHALL update on every rising edge regardless of in_valid, so back-to-back inputs produce back-to-back results.
REQ-018 out_valid SHALL be in_valid delayed by one clock.
REQ-019 No backpressure: the block SHALL accept one operation per cycle with no stall or ready signal.
REQ-020 No combinational path SHALL exist from any input to any output.
REQ-021 Boundary cases: A=0, B=2^WIDTH-1, Bin=1 SHALL give D=0, Bout=1; A=B, Bin=0 SHALL give D=0, Bout=0; A=B, Bin=1 SHALL give D=all-ones, Bout=1.
REQ-022 X/Z on inputs need not be resolved; with known inputs, outputs SHALL always be known.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for a clock edge, force D=0, Bout=0, out_valid=0.
REQ-024 While rst_n is low, outputs SHALL hold these values irrespective of clk and inputs.
REQ-025 After rst_n deasserts, the first rising edge SHALL capture the inputs normally; there is no extra warm-up cycle.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; the pre-reset result is never presented.

Verification
REQ-027 WIDTH=1, in_valid=1, apply all 8 {A,B,Bin} combinations 000..111, one per clock -> next-cycle {D,Bout} = 00,11,11,01,10,00,00,11 respectively.
REQ-028 WIDTH=8: A=8'h05, B=8'h03, Bin=1 -> D=8'h01, Bout=0; A=8'h00, B=8'hFF, Bin=1 -> D=8'h00, Bout=1; A=8'h10, B=8'h10, Bin=1 -> D=8'hFF, Bout=1.
REQ-029 Latency/valid: pulse in_valid for one cycle with A=1, B=0, Bin=0 (WIDTH=1) -> out_valid high for exactly the following cycle with D=1, Bout=0.
REQ-030 Async reset: drive A=0, B=1, Bin=0 so that registered D=1, Bout=1, out_valid=1, then drop rst_n between edges -> all outputs 0 before the next edge; they stay 0 until the first edge after release.
REQ-031 Random: at least 10k random A/B/Bin/in_valid vectors for WIDTH in {1,8,64} compared against the REQ-011 model delayed one cycle -> zero mismatches.
